// File: rtl/my_seg_display.sv
// Eight-digit multiplexed hex display driver with a byte-writable 32-bit value register.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_LEADING_ZERO_EN.
module my_seg_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      disp_reg;
    logic [31:0]      disp_next;
    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic             wrap;
    logic [3:0]       nibble;
    logic             blank;
    logic [7:0]       seg_next;
    logic [7:0]       dig_next;

    function automatic logic [7:0] hex_decode(input logic [3:0] h);
        logic [7:0] s;
        unique case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_comb begin
        disp_next = disp_reg;
        if (we) begin
            for (int n = 0; n < 4; n++) begin
                if (wstrb[n]) begin
                    disp_next[8*n +: 8] = wdata[8*n +: 8];
                end
            end
        end
    end

    assign wrap   = (div_cnt == CNT_MAX);
    assign nibble = disp_reg[{idx, 2'b00} +: 4];

    // Blank a digit when it and every more-significant nibble are zero; digit 0 always shows.
    always_comb begin
`ifdef SEG_BLANK_LEADING_ZERO_EN
        blank = (idx != 3'd0) && ((disp_reg >> {idx, 2'b00}) == 32'h0);
`else
        blank = 1'b0;
`endif
        seg_next = blank ? 8'hFF : (hex_decode(nibble) | 8'h80);
        dig_next = ~(8'h01 << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_reg <= 32'h0;
            rdata    <= 32'h0;
            div_cnt  <= '0;
            idx      <= 3'd0;
            dig_en   <= 8'hFF;
            seg      <= 8'hFF;
        end else begin
            disp_reg <= disp_next;
            rdata    <= disp_reg;
            div_cnt  <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) begin
                idx <= idx + 3'd1;
            end
            dig_en   <= dig_next;
            seg      <= seg_next;
        end
    end

endmodule

// File: tb/tb_my_seg_display.sv
// Scoreboard bench for my_seg_display (SCAN_DIV=4): stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them. Honours SEG_BLANK_LEADING_ZERO_EN when defined.
module tb_my_seg_display;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    my_seg_display #(.SCAN_DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .wstrb  (wstrb),
        .wdata  (wdata),
        .rdata  (rdata),
        .dig_en (dig_en),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  de;
        logic [7:0]  sg;
        bit          chk_rd;
        logic [31:0] rd;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    typedef logic [7:0] seg_arr_t [8];
    localparam seg_arr_t SEG_ZERO = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    localparam seg_arr_t SEG_89 = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    localparam seg_arr_t SEG_12 = '{8'h8E, 8'h86, 8'hA4, 8'hF9, 8'h83, 8'h88, 8'h90, 8'h80};
    localparam seg_arr_t SEG_01 = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    localparam seg_arr_t SEG_40 = '{8'hC0, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

    always @(posedge clk) cyc <= cyc + 1;

    // Digit shown after the e-th edge following reset release.
    function automatic int slot(input int e);
        return ((e - 1) / DIV) % 8;
    endfunction

    function automatic logic [7:0] exp_dig(input int s);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << s);
    endfunction

    function automatic logic [7:0] exp_seg(input logic [7:0] hand, input int d,
                                           input logic [31:0] v);
`ifdef SEG_BLANK_LEADING_ZERO_EN
        if (d != 0 && (v >> (4 * d)) == 32'h0) return 8'hFF;
`endif
        return hand;
    endfunction

    task automatic push(input int c, input logic [7:0] de, input logic [7:0] sg,
                        input bit chk, input logic [31:0] rd, input string nm);
        exp_t e;
        e.cyc = c; e.de = de; e.sg = sg; e.chk_rd = chk; e.rd = rd; e.nm = nm;
        q.push_back(e);
    endtask

    // Expected outputs for edges base+e0 .. base+e1 with a fixed display value.
    task automatic push_scan(input int base, input int e0, input int e1, input seg_arr_t h,
                             input logic [31:0] v, input string nm);
        for (int e = e0; e <= e1; e++) begin
            push(base + e, exp_dig(slot(e)), exp_seg(h[slot(e)], slot(e), v), 1'b1, v, nm);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_run++; n_fail++;
                $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.nm, e.cyc, cyc);
            end else begin
                n_run++;
                if (dig_en !== e.de) begin
                    n_fail++;
                    $display("FAIL %s dig_en @%0d: got %h expected %h", e.nm, cyc, dig_en, e.de);
                end
                n_run++;
                if (seg !== e.sg) begin
                    n_fail++;
                    $display("FAIL %s seg @%0d: got %h expected %h", e.nm, cyc, seg, e.sg);
                end
                if (e.chk_rd) begin
                    n_run++;
                    if (rdata !== e.rd) begin
                        n_fail++;
                        $display("FAIL %s rdata @%0d: got %h expected %h", e.nm, cyc, rdata,
                                 e.rd);
                    end
                end
            end
        end
    end

    initial begin
        int r;
        int r2;
        // Reset with a write pending: must be discarded.
        rst = 1'b1; we = 1'b1; wstrb = 4'hF; wdata = 32'h12345678;
        step(); step(); step();
        push(cyc, 8'hFF, 8'hFF, 1'b1, 32'h0, "reset");
        rst = 1'b0; we = 1'b0;
        r = cyc;
        push_scan(r, 1, 40, SEG_ZERO, 32'h0, "idle_scan");
        repeat (40) step();

        // Full-word write.
        we = 1'b1; wstrb = 4'hF; wdata = 32'h89ABCDEF;
        push(r + 41, exp_dig(slot(41)), exp_seg(8'hC0, slot(41), 32'h0), 1'b1, 32'h0,
             "write_full_pre");
        push_scan(r, 42, 73, SEG_89, 32'h89ABCDEF, "write_full");
        step();
        we = 1'b0;
        while (cyc < r + 73) step();

        // Byte-lane write, then a strobe-less write that must change nothing.
        we = 1'b1; wstrb = 4'b0010; wdata = 32'h0000_1200;
        push(r + 74, exp_dig(slot(74)), SEG_89[slot(74)], 1'b1, 32'h89ABCDEF, "byte_pre");
        push_scan(r, 75, 106, SEG_12, 32'h89AB12EF, "byte_write");
        step();
        wstrb = 4'h0; wdata = 32'hFFFFFFFF;
        step();
        we = 1'b0;
        while (cyc < r + 107) step();

        // Write sampled on the divider wrap edge (r+108).
        we = 1'b1; wstrb = 4'hF; wdata = 32'h01234567;
        push(r + 108, exp_dig(slot(108)), SEG_12[slot(108)], 1'b1, 32'h89AB12EF, "wrap_pre");
        push_scan(r, 109, 140, SEG_01, 32'h01234567, "wrap_write");
        step();
        we = 1'b0;
        while (cyc < r + 149) step();

        // Reset mid-slot while idx=5 with a concurrent write.
        rst = 1'b1; we = 1'b1; wstrb = 4'hF; wdata = 32'hDEADBEEF;
        push(r + 150, 8'hFF, 8'hFF, 1'b1, 32'h0, "mid_reset");
        step();
        rst = 1'b0; we = 1'b0;
        r2 = cyc;
        push_scan(r2, 1, 12, SEG_ZERO, 32'h0, "restart");
        repeat (12) step();

        // Leading-zero cases.
        we = 1'b1; wstrb = 4'hF; wdata = 32'h00000040;
        push_scan(r2, 14, 45, SEG_40, 32'h00000040, "val_40");
        step();
        we = 1'b0;
        while (cyc < r2 + 45) step();
        we = 1'b1; wstrb = 4'hF; wdata = 32'h0;
        push_scan(r2, 47, 78, SEG_ZERO, 32'h0, "val_0");
        step();
        we = 1'b0;

        for (int i = 0; i < 100 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            n_run++; n_fail++;
            $display("FAIL drain: %0d checks pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
